tri_bus_arbiter: RTL
====================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, shared bus data width in bits.
REQ-002 SHALL have parameter HOLD_MAX, default 4, maximum consecutive GRANT cycles per ownership (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester bus request, bit i = requester i.
REQ-006 SHALL have port din  input  4*WIDTH  requester data, slice [i*WIDTH +: WIDTH] = requester i.
REQ-007 SHALL have port bus  inout  WIDTH  shared tri net, driven only through four internal conditional drivers.
REQ-008 SHALL have port gnt  output  4  one-hot-or-zero grant, registered.
REQ-009 SHALL have port bus_valid  output  1  high while a requester owns and drives bus.
REQ-010 SHALL have port bus_q  output  WIDTH  registered sample of bus.
REQ-011 SHALL have port hold_expired  output  1  one-cycle pulse when an ownership is ended by HOLD_MAX.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, TURN; state, gnt, owner index, last-owner pointer and hold counter are registers.
REQ-013 SHALL drive bus slice from requester i as din slice i when gnt[i]=1, else high-Z; all four drivers share the tri net `bus`.
REQ-014 SHALL guarantee at most one gnt bit high in any cycle; gnt=0 in IDLE and TURN.
REQ-015 SHALL, in IDLE with req!=0 at an edge, select the owner round-robin: the first set req bit searching upward from (last_owner+1) mod 4, wrapping; enter GRANT with gnt set at that edge (1-cycle request-to-grant latency).
REQ-016 SHALL, in IDLE with req=0, remain in IDLE.
REQ-017 SHALL, in GRANT, count owned cycles in the hold counter, starting at 1 on the granting edge.
REQ-018 SHALL leave GRANT for TURN when req[owner]=0 at an edge, or when the hold counter equals HOLD_MAX at an edge (whichever occurs first); gnt clears at that edge.
REQ-019 SHALL pulse hold_expired for exactly the cycle following an exit caused by HOLD_MAX while req[owner] was still high; no pulse on voluntary release.
REQ-020 SHALL spend exactly one cycle in TURN (bus fully undriven, turnaround), then arbitrate as in IDLE: req!=0 -> GRANT with new owner; else IDLE.
REQ-021 SHALL update last_owner to the owner on entering GRANT; a sole requester may be re-granted after TURN.
REQ-022 SHALL ignore req changes of non-owners during GRANT; they are evaluated only at arbitration edges.
REQ-023 SHALL set bus_valid = (state==GRANT).
REQ-024 SHALL load bus_q with the value of bus at every edge where bus_valid=1; hold otherwise (bus_q lags bus by one cycle).
REQ-025 SHALL not depend on bus value for any control decision.

Reset
REQ-026 SHALL, on rst_n low, immediately (without a clock) set state=IDLE, gnt=0, bus fully high-Z, bus_valid=0, hold_expired=0, bus_q=0, hold counter=0, last_owner=3 (so first grant search begins at requester 0).
REQ-027 SHALL, on rst_n low mid-GRANT, release bus within the same time step and resume with normal arbitration at the first edge with rst_n high.

Verification
REQ-028 SHALL verify: reset, then req=4'b0001, din0=8'hA5 -> gnt=0001 one edge later, bus=8'hA5, bus_q=8'hA5 one further edge later, bus_valid=1.
REQ-029 SHALL verify: req=4'b1111 held constantly, HOLD_MAX=4 -> grants 0,1,2,3,0 in order, each 4 cycles of GRANT then 1 TURN cycle with bus=Z, hold_expired pulsed after each.
REQ-030 SHALL verify: owner 2 drops req after 2 cycles with req=4'b0100 only -> TURN one cycle, then IDLE, no hold_expired, bus=Z in TURN and IDLE.
REQ-031 SHALL verify: last_owner=3, req=4'b1010 -> owner 1 granted (wrap search from 0), then owner 3 after TURN.
REQ-032 SHALL verify: rst_n driven low in the middle of GRANT -> gnt=0, bus=Z, bus_valid=0 before the next clock edge; release and req=4'b0001 -> normal grant of requester 0.
REQ-033 SHALL verify, every cycle via assertion: gnt is zero or one-hot, and bus carries no X while bus_valid=1.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Four-requester round-robin arbiter for a shared tri-state bus.
// The granted requester drives `bus` through its own conditional driver;
// every ownership is followed by one undriven turnaround cycle so that
// no two drivers ever overlap on the net. Ownership is capped at HOLD_MAX
// consecutive cycles, and a capped (not voluntary) release is flagged
// with a one-cycle hold_expired pulse.
module tri_bus_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    inout  tri logic [WIDTH-1:0] bus,
    output logic [3:0]           gnt,
    output logic                 bus_valid,
    output logic [WIDTH-1:0]     bus_q,
    output logic                 hold_expired,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] owner, owner_n;
    logic [1:0] last_owner, last_owner_n;
    logic [3:0] hold_cnt, hold_cnt_n;
    logic       hold_expired_n;
    logic [1:0] pick;

    // Round-robin search: first set request bit going upward from
    // last_owner+1, wrapping; the 2-bit index wraps naturally.
    always_comb begin
        pick = last_owner;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_owner + 2'(k)]) begin
                pick = last_owner + 2'(k);
            end
        end
    end

    // Next-state and registered-output logic for the ownership FSM.
    always_comb begin
        state_n        = state;
        gnt_n          = gnt;
        owner_n        = owner;
        last_owner_n   = last_owner;
        hold_cnt_n     = hold_cnt;
        hold_expired_n = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (req != 4'b0000) begin
                    state_n      = GRANT;
                    gnt_n        = 4'b0001 << pick;
                    owner_n      = pick;
                    last_owner_n = pick;
                    hold_cnt_n   = 4'd1;
                end else begin
                    state_n    = IDLE;
                    gnt_n      = 4'b0000;
                    hold_cnt_n = 4'd0;
                end
            end
            GRANT: begin
                // A voluntary release wins over the cap when both happen
                // at the same edge, so no pulse is raised in that case.
                if (!req[owner]) begin
                    state_n    = TURN;
                    gnt_n      = 4'b0000;
                    hold_cnt_n = 4'd0;
                end else if (hold_cnt == 4'(HOLD_MAX)) begin
                    state_n        = TURN;
                    gnt_n          = 4'b0000;
                    hold_cnt_n     = 4'd0;
                    hold_expired_n = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_n    = IDLE;
                gnt_n      = 4'b0000;
                hold_cnt_n = 4'd0;
            end
        endcase
    end

    // FSM and arbitration registers; reset clears grants without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= 4'b0000;
            owner        <= 2'd0;
            last_owner   <= 2'd3;
            hold_cnt     <= 4'd0;
            hold_expired <= 1'b0;
        end else begin
            state        <= state_n;
            gnt          <= gnt_n;
            owner        <= owner_n;
            last_owner   <= last_owner_n;
            hold_cnt     <= hold_cnt_n;
            hold_expired <= hold_expired_n;
        end
    end

    // Capture the bus on every owned cycle; hold the last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q <= '0;
        end else if (bus_valid) begin
            bus_q <= bus;
        end
    end

    // One conditional driver per requester onto the shared net.
    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign bus = gnt[i] ? din[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
    end

    assign bus_valid = (state == GRANT);
    assign state_dbg = state;

endmodule
